// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, payload field positions and FSM encodings for the MEM stage.
// Contents:
//   TO_MEM_DATA_W / TO_WB_DATA_W   payload widths between EX->MEM and MEM->WB
//   TM_* / TW_*                    bit positions of each field inside those payloads
//   mem_state_e                    SRAM transaction controller states
//   is_mem_op()                    true for any instruction that touches data SRAM
package mem_stage_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int DEST_W_DEF    = 5;
    localparam int TO_MEM_DATA_W = 72;
    localparam int TO_WB_DATA_W  = 38;

    // to_MEM_data = {alu_result, rkd_value, mem_we, res_from_mem, dest, gr_we}
    localparam int TM_ALU_LSB  = 40;
    localparam int TM_RKD_LSB  = 8;
    localparam int TM_MEM_WE   = 7;
    localparam int TM_RES_MEM  = 6;
    localparam int TM_DEST_LSB = 1;
    localparam int TM_GR_WE    = 0;

    // to_WB_data = {final_result, dest, gr_we}
    localparam int TW_RES_LSB  = 6;
    localparam int TW_DEST_LSB = 1;
    localparam int TW_GR_WE    = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_mem_op(input logic mem_we, input logic res_from_mem);
        return mem_we | res_from_mem;
    endfunction

endpackage

// File: rtl/mem_sram_fsm.sv
// mem_sram_fsm: one-transaction-at-a-time data-SRAM controller (IDLE/REQ/WAIT/DONE) with load-data buffer.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load                  MEM stage takes a new slot this cycle (MEM_allow_in)
//   start                 the instruction entering that slot is a memory op
//   mem_we, addr, wdata   latched instruction fields driving the request
//   done                  transaction finished (state DONE)
//   rdata_buf             load data captured on data_ok
//   data_sram_*           SRAM request/response handshake
module mem_sram_fsm
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              start,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata_buf,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [DATA_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic              data_sram_addr_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              data_sram_data_ok
);

    mem_state_e state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rdata_buf <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && data_sram_data_ok)
                rdata_buf <= data_sram_rdata;
        end
    end

    // A new slot (handoff or empty stage) overrides the transaction progress:
    // it either launches the next request immediately or parks in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ:   state_nxt = data_sram_addr_ok ? S_WAIT : S_REQ;
            S_WAIT:  state_nxt = data_sram_data_ok ? S_DONE : S_WAIT;
            default: state_nxt = state;
        endcase
        if (load)
            state_nxt = start ? S_REQ : S_IDLE;
    end

    // Request fields come straight from the latched payload, so they are
    // stable for as long as REQ waits on addr_ok.
    assign done            = (state == S_DONE);
    assign data_sram_req   = (state == S_REQ);
    assign data_sram_wr    = mem_we;
    assign data_sram_addr  = addr;
    assign data_sram_wdata = wdata;
    assign data_sram_wstrb = {(DATA_W/8){mem_we}};

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; latches EX payload, performs one data-SRAM access per memory op, hands result to WB.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   EX_to_MEM_valid/to_MEM_data  upstream instruction and payload {alu_result, rkd_value, mem_we, res_from_mem, dest, gr_we}
//   MEM_allow_in               MEM accepts a new instruction
//   WB_allow_in                downstream accepts
//   MEM_to_WB_valid/to_WB_data   result to WB {final_result, dest, gr_we}
//   data_sram_*                data-SRAM handshake
//   mem_fwd_bus                only with MEM_FWD_EN: {valid&gr_we, dest, final_result, mem_pending} for ID bypass/stall
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          EX_to_MEM_valid,
    input  logic [2*DATA_W+DEST_W+2:0]    to_MEM_data,
    output logic                          MEM_allow_in,
    input  logic                          WB_allow_in,
    output logic                          MEM_to_WB_valid,
    output logic [DATA_W+DEST_W:0]        to_WB_data,
    output logic                          data_sram_req,
    output logic                          data_sram_wr,
    output logic [DATA_W-1:0]             data_sram_addr,
    output logic [DATA_W-1:0]             data_sram_wdata,
    output logic [DATA_W/8-1:0]           data_sram_wstrb,
`ifdef MEM_FWD_EN
    output logic [DATA_W+DEST_W+1:0]      mem_fwd_bus,
`endif
    input  logic                          data_sram_addr_ok,
    input  logic [DATA_W-1:0]             data_sram_rdata,
    input  logic                          data_sram_data_ok
);

    localparam int IN_W = 2*DATA_W + DEST_W + 3;

    logic              mem_valid;
    logic [IN_W-1:0]   payload;
    logic [DATA_W-1:0] alu_result, rkd_value, rdata_buf, final_result;
    logic [DEST_W-1:0] dest;
    logic              mem_we, res_from_mem, gr_we, is_mem, ready_go, done;
    logic              accept, in_is_mem;

    assign alu_result   = payload[IN_W-1 -: DATA_W];
    assign rkd_value    = payload[DEST_W+3 +: DATA_W];
    assign mem_we       = payload[DEST_W+2];
    assign res_from_mem = payload[DEST_W+1];
    assign dest         = payload[DEST_W:1];
    assign gr_we        = payload[0];

    assign in_is_mem = is_mem_op(to_MEM_data[DEST_W+2], to_MEM_data[DEST_W+1]);
    assign is_mem    = is_mem_op(mem_we, res_from_mem);
    assign ready_go  = ~is_mem | done;

    assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
    assign MEM_to_WB_valid = mem_valid & ready_go;
    assign accept          = EX_to_MEM_valid & MEM_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            payload   <= '0;
        end else if (MEM_allow_in) begin
            mem_valid <= EX_to_MEM_valid;
            if (EX_to_MEM_valid)
                payload <= to_MEM_data;
        end
    end

    mem_sram_fsm #(.DATA_W(DATA_W)) u_fsm (
        .clk               (clk),
        .reset             (reset),
        .load              (MEM_allow_in),
        .start             (accept & in_is_mem),
        .mem_we            (mem_we),
        .addr              (alu_result),
        .wdata             (rkd_value),
        .done              (done),
        .rdata_buf         (rdata_buf),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok)
    );

    // Stores report alu_result; only loads return SRAM data.
    assign final_result = res_from_mem ? rdata_buf : alu_result;
    assign to_WB_data   = {final_result, dest, gr_we};

`ifdef MEM_FWD_EN
    logic mem_pending;
    assign mem_pending = mem_valid & res_from_mem & ~done;
    assign mem_fwd_bus = {mem_valid & gr_we, dest, final_result, mem_pending};
`endif

endmodule
